ro_edge_counter: RTL

Sits directly downstream of the window timer. Counts rising edges of the free-running ring-oscillator output between consecutive window_done pulses. At each window boundary it snapshots the count and streams it MSB-first as bytes over a valid/ready handshake to the UART transmitter. Drops a snapshot, and flags the drop, if the previous one is still being sent.

---
 rtl/ro_edge_counter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/ro_edge_counter.sv
// Ring-oscillator edge counter: counts synchronised rising edges per measurement window and
// streams each window's count MSB-first as bytes over a valid/ready handshake.
module ro_edge_counter #(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ro_in,
    input  logic       window_done,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       frame_drop
);
    // state | meaning
    // IDLE  | no frame in flight, waiting for window_done
    // SEND  | presenting the top byte of shift_q with tx_valid high

    localparam int NBYTES = CNT_W / 8;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   ro_edge;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       shift_q, shift_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   drop_q, drop_d;
    logic                   xfer, last_xfer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ro_in};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign ro_edge = sync_q[SYNC_STAGES-1] & ~hist_q;

    // cnt_inc doubles as the snapshot: an edge in the window_done cycle closes into this window.
    always_comb begin
        cnt_inc = (&cnt_q) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, ro_edge};
        cnt_d   = window_done ? '0 : cnt_inc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign xfer      = (state_q == SEND) && tx_ready;
    assign last_xfer = xfer && (idx_q == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        drop_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (window_done) begin
                    state_d = SEND;
                    shift_d = cnt_inc;
                    idx_d   = '0;
                end
            end
            SEND: begin
                if (last_xfer) begin
                    // A window closing exactly on the final handshake chains straight into a new frame.
                    if (window_done) begin
                        shift_d = cnt_inc;
                    end else begin
                        state_d = IDLE;
                        shift_d = shift_q << 8;
                    end
                    idx_d = '0;
                end else begin
                    if (xfer) begin
                        shift_d = shift_q << 8;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                    drop_d = window_done;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_valid   = (state_q == SEND);
        busy       = (state_q == SEND);
        tx_data    = (state_q == SEND) ? shift_q[CNT_W-1 -: 8] : 8'h00;
        frame_drop = drop_q;
    end

endmodule
